// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator stage.
package sum_acc_pkg;

    typedef enum logic {
        ACC_S,
        OUT_S
    } acc_state_t;

    localparam int unsigned IN_W_DEF  = 3;
    localparam int unsigned ACC_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/sum_accumulator_if.sv
// Input beat stream and frame-result stream of the sum accumulator.
interface sum_accumulator_if
    import sum_acc_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/sum_accumulator_ripple_add.sv
// acc_ripple_add: combinational W-bit ripple-carry adder from full-adder cells, cin tied to 0.
module acc_ripple_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates framed sum words and emits total/count/overflow per frame.
// Optional macro ACC_SATURATE_EN clamps the total at all-ones on overflow instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sum_accumulator_if.slave  bus
);

    acc_state_t       state;
    acc_state_t       state_nxt;
    logic             in_rdy;
    logic             out_vld;
    logic             take;
    logic             give;
    logic [IN_W-1:0]  in_word;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             ovf;

    assign in_word = bus.in_data;
    assign in_ext  = ACC_W'(in_word);
    assign take    = bus.in_valid & in_rdy;
    assign give    = out_vld & bus.out_ready;

    acc_ripple_add #(.W(ACC_W)) u_add (
        .a    (acc),
        .b    (in_ext),
        .sum  (add_sum),
        .cout (carry)
    );

`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero beat carries out again, so the total stays pinned.
    assign acc_nxt = carry ? '1 : add_sum;
`else
    assign acc_nxt = add_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC_S;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC_S:   if (take && bus.in_last) state_nxt = OUT_S;
            OUT_S:   if (give) state_nxt = ACC_S;
            default: state_nxt = ACC_S;
        endcase
    end

    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state)
            ACC_S:   in_rdy  = 1'b1;
            OUT_S:   out_vld = 1'b1;
            default: in_rdy  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (take) begin
            acc   <= acc_nxt;
            count <= (count == '1) ? count : count + 1'b1;
            ovf   <= ovf | carry;
        end else if (give) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = acc;
    assign bus.out_count = count;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed frames plus random frames against a whole-frame arithmetic model.
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(3), .ACC_W(8), .CNT_W(8)) bus ();

    sum_accumulator #(.IN_W(3), .ACC_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 3'($urandom);
        bus.in_last  = 1'($urandom);
        @(negedge clk);
    endtask

    // Presents one beat at a negedge; it is accepted at the following posedge.
    task automatic send_beat(input int unsigned d, input bit last);
        int unsigned budget = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 3'(d);
        bus.in_last  = last;
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input int unsigned es, input int unsigned ec, input bit eo,
                              input int unsigned hold);
        int unsigned budget = 0;
        while (!bus.out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("out_sum", {24'd0, bus.out_sum}, es);
        chk("out_count", {24'd0, bus.out_count}, ec);
        chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, eo});
        for (int unsigned h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 3'($urandom);
            bus.in_last  = 1'b1;
            @(negedge clk);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_out_sum", {24'd0, bus.out_sum}, es);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_sum_clear", {24'd0, bus.out_sum}, 32'd0);
    endtask

    // gap < 0 selects a random 0..2 idle cycles between beats.
    task automatic run_frame(input int unsigned q[$], input int gap, input int unsigned hold);
        longint unsigned total = 0;
        int unsigned es, ec;
        bit eo;
        foreach (q[i]) total += q[i];
        ec = (q.size() > 255) ? 255 : q.size();
        eo = (total > 255);
`ifdef ACC_SATURATE_EN
        es = eo ? 255 : int'(total);
`else
        es = int'(total % 256);
`endif
        foreach (q[i]) begin
            int unsigned g;
            send_beat(q[i], i == q.size() - 1);
            if (i == q.size() - 1) begin
                chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
            end else begin
                g = (gap < 0) ? $urandom_range(2, 0) : gap;
                repeat (g) idle_cycle();
            end
        end
        get_result(es, ec, eo, hold);
    endtask

    initial begin
        int unsigned q[$];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_sum", {24'd0, bus.out_sum}, 32'd0);
        chk("rst_out_count", {24'd0, bus.out_count}, 32'd0);
        chk("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        rst = 1'b0;

        q = {3, 5, 7};
        run_frame(q, 0, 0);
        run_frame(q, 0, 5);

        q = {};
        repeat (37) q.push_back(7);
        run_frame(q, 0, 1);

        send_beat(6, 1'b0);
        send_beat(6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_out_sum", {24'd0, bus.out_sum}, 32'd0);
        chk("abort_out_count", {24'd0, bus.out_count}, 32'd0);
        q = {1};
        run_frame(q, 0, 0);

        q = {2, 4};
        run_frame(q, 1, 0);

        for (int f = 0; f < 30; f++) begin
            int unsigned len;
            len = $urandom_range(60, 1);
            q = {};
            for (int unsigned b = 0; b < len; b++) q.push_back($urandom_range(7, 0));
            run_frame(q, -1, $urandom_range(3, 0));
            repeat ($urandom_range(2, 0)) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
